// File: rtl/keypad_scanner.sv
// Column scanner and row debouncer for the 4x3 lock keypad.
// Emits the accepted key code plus key-valid and key-still-held levels.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [3:0] Row,
    output logic [2:0] Col,
    output logic [3:0] Code_1,
    output logic       Valid_1,
    output logic       S_Row
);

    localparam int unsigned WIN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [2:0]       col_q, col_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             s_row_q, s_row_d;

    logic             sample_c;
    logic             single_c;
    logic             same_c;
    logic [1:0]       row_idx_c;
    logic [1:0]       col_pos_c;
    logic [2:0]       col_rot_c;
    logic [CNT_W-1:0] cnt_inc_c;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'd11;
                2'd1:    code = 4'd0;
                default: code = 4'd10;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    // Only a sample with exactly one low row bit names a key.
    always_comb begin
        single_c  = 1'b0;
        row_idx_c = 2'd0;
        case (row_sync_q)
            4'b1110: begin single_c = 1'b1; row_idx_c = 2'd0; end
            4'b1101: begin single_c = 1'b1; row_idx_c = 2'd1; end
            4'b1011: begin single_c = 1'b1; row_idx_c = 2'd2; end
            4'b0111: begin single_c = 1'b1; row_idx_c = 2'd3; end
            default: ;
        endcase
    end

    assign sample_c  = (win_q == WIN_LAST);
    assign same_c    = single_c && (row_idx_c == key_row_q);
    assign col_rot_c = {col_q[1:0], col_q[2]};
    assign col_pos_c = !col_q[0] ? 2'd0 : (!col_q[1] ? 2'd1 : 2'd2);
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next-state and output logic; all outputs are registered.
    always_comb begin
        state_d   = state_q;
        win_d     = sample_c ? '0 : win_q + WIN_W'(1);
        cnt_d     = cnt_q;
        key_row_d = key_row_q;
        col_d     = col_q;
        code_d    = code_q;
        valid_d   = valid_q;
        s_row_d   = s_row_q;

        case (state_q)
            SCAN: begin
                valid_d = 1'b0;
                if (sample_c) begin
                    if (single_c) begin
                        key_row_d = row_idx_c;
                        cnt_d     = CNT_W'(1);
                        state_d   = PRESS;
                    end else begin
                        col_d = col_rot_c;
                    end
                end
            end
            PRESS: begin
                valid_d = 1'b0;
                if (sample_c) begin
                    if (same_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_DONE) begin
                            code_d  = key_code(key_row_q, col_pos_c);
                            cnt_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_rot_c;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                valid_d = 1'b1;
                if (sample_c && !same_c) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                valid_d = 1'b1;
                if (sample_c) begin
                    if (same_c) begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_DONE) begin
                            valid_d = 1'b0;
                            cnt_d   = '0;
                            col_d   = col_rot_c;
                            state_d = SCAN;
                        end
                    end
                end
            end
        endcase

        if (sample_c) begin
            s_row_d = ((state_q == HELD) || (state_q == RELEASE)) && same_c;
        end
    end

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state_q    <= SCAN;
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            win_q      <= '0;
            cnt_q      <= '0;
            key_row_q  <= 2'd0;
            col_q      <= 3'b110;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            s_row_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_meta_q <= Row;
            row_sync_q <= row_meta_q;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            key_row_q  <= key_row_d;
            col_q      <= col_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            s_row_q    <= s_row_d;
        end
    end

    assign Col     = col_q;
    assign Code_1  = code_q;
    assign Valid_1 = valid_q;
    assign S_Row   = s_row_q;

endmodule
